// File: rtl/link_parameter_loader.sv
// Writer end of the per-link parameter systolic chain.
// Buffers one set of (weight, boundary) words and shifts it into the chain head.
package link_params_pkg;
    localparam int STAGE_IDLE = 0;
    localparam int STAGE_MEASUREMENT = 1;
    localparam int STAGE_PARAMETERS_LOADING = 2;
    localparam int STAGE_DECODING = 3;
endpackage

module link_parameter_loader
    import link_params_pkg::*;
#(
    parameter int NUM_LINKS = 8,
    parameter int MAX_WEIGHT = 2,
    parameter int LINK_BIT_WIDTH = $clog2(MAX_WEIGHT + 1),
    parameter int STAGE_WIDTH = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [STAGE_WIDTH-1:0]    global_stage,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [LINK_BIT_WIDTH-1:0] s_weight,
    input  logic [1:0]                s_boundary,
    input  logic                      s_last,
    output logic [LINK_BIT_WIDTH-1:0] weight_out,
    output logic [1:0]                boundary_condition_out,
    output logic                      params_ready,
    output logic                      load_last,
    output logic                      load_done,
    output logic                      load_error
);

    localparam int PW = $clog2(NUM_LINKS);
    localparam logic [PW-1:0] LAST = PW'(NUM_LINKS - 1);

    typedef enum logic [1:0] {IDLE, FULL, STREAM} state_t;

    state_t                    state_q, state_d;
    logic [PW-1:0]             wr_q, wr_d;
    logic [PW-1:0]             rd_q, rd_d;
    logic                      err_d, done_d, we;
    logic                      active_q;
    logic                      loading;
    logic [LINK_BIT_WIDTH+1:0] mem [NUM_LINKS];

    assign loading = (global_stage == STAGE_WIDTH'(STAGE_PARAMETERS_LOADING));

    always_comb begin
        state_d = state_q;
        wr_d = wr_q;
        rd_d = rd_q;
        err_d = load_error;
        done_d = 1'b0;
        we = 1'b0;
        s_ready = 1'b0;
        params_ready = 1'b0;
        load_last = 1'b0;
        weight_out = '0;
        boundary_condition_out = 2'd2;
        unique case (state_q)
            IDLE: begin
                s_ready = active_q;
                if (s_valid && active_q) begin
                    we = 1'b1;
                    wr_d = wr_q + 1'b1;
                    if (wr_q == '0) err_d = 1'b0;
                    if (s_last && wr_q == LAST) begin
                        state_d = FULL;
                        wr_d = '0;
                    end else if (s_last || wr_q == LAST) begin
                        err_d = 1'b1;
                        wr_d = '0;
                    end
                end
                // Loading with nothing buffered is a controller error.
                if (loading) err_d = 1'b1;
            end
            FULL: begin
                params_ready = 1'b1;
                {weight_out, boundary_condition_out} = mem[0];
                if (loading) begin
                    state_d = STREAM;
                    rd_d = rd_q + 1'b1;
                end
            end
            STREAM: begin
                params_ready = 1'b1;
                {weight_out, boundary_condition_out} = mem[rd_q];
                if (loading) begin
                    if (rd_q == LAST) begin
                        load_last = 1'b1;
                        done_d = 1'b1;
                        state_d = IDLE;
                        rd_d = '0;
                    end else begin
                        rd_d = rd_q + 1'b1;
                    end
                end else begin
                    err_d = 1'b1;
                    state_d = IDLE;
                    rd_d = '0;
                    wr_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            wr_q <= '0;
            rd_q <= '0;
            load_error <= 1'b0;
            load_done <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q <= wr_d;
            rd_q <= rd_d;
            load_error <= err_d;
            load_done <= done_d;
            active_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[wr_q] <= {s_weight, s_boundary};
    end

endmodule

// File: tb/tb_link_parameter_loader.sv
// Directed bench for link_parameter_loader with an 8-link model chain.
module tb_link_parameter_loader;
    import link_params_pkg::*;

    localparam int N = 8;
    localparam logic [2:0] PL = 3'(STAGE_PARAMETERS_LOADING);

    logic       clk = 0;
    logic       reset = 0;
    logic [2:0] global_stage = '0;
    logic       s_valid = 0;
    logic       s_ready;
    logic [1:0] s_weight = '0;
    logic [1:0] s_boundary = '0;
    logic       s_last = 0;
    logic [1:0] weight_out;
    logic [1:0] boundary_condition_out;
    logic       params_ready, load_last, load_done, load_error;

    link_parameter_loader #(.NUM_LINKS(N), .MAX_WEIGHT(2), .STAGE_WIDTH(3)) dut (
        .clk(clk), .reset(reset), .global_stage(global_stage),
        .s_valid(s_valid), .s_ready(s_ready), .s_weight(s_weight),
        .s_boundary(s_boundary), .s_last(s_last),
        .weight_out(weight_out),
        .boundary_condition_out(boundary_condition_out),
        .params_ready(params_ready), .load_last(load_last),
        .load_done(load_done), .load_error(load_error)
    );

    always #5 clk = ~clk;

    logic [1:0] cw [N];
    logic [1:0] cb [N];
    always @(posedge clk) begin
        if (global_stage == PL) begin
            cw[0] <= weight_out;
            cb[0] <= boundary_condition_out;
            for (int i = 1; i < N; i++) begin
                cw[i] <= cw[i-1];
                cb[i] <= cb[i-1];
            end
        end
    end

    typedef struct {
        logic [1:0] w;
        logic [1:0] b;
        logic [1:0] lw;
        logic [1:0] lb;
    } vec_t;
    vec_t vec [N];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send_range(input int from, input int to,
                              input int last_idx, input bit toggle);
        for (int k = from; k <= to; k++) begin
            int guard;
            if (toggle) begin
                @(negedge clk);
                s_valid = 0;
            end
            @(negedge clk);
            s_valid = 1;
            s_weight = vec[k].w;
            s_boundary = vec[k].b;
            s_last = (k == last_idx);
            #1;
            guard = 0;
            while (!s_ready && guard < 20) begin
                @(negedge clk);
                #1;
                guard++;
            end
            chk("accept", 32'(s_ready), 1);
        end
        @(negedge clk);
        s_valid = 0;
        s_last = 0;
        #1;
    endtask

    task automatic run_load(input int n);
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            global_stage = PL;
            #1;
            chk($sformatf("load_last_c%0d", c), 32'(load_last), 32'(c == N));
            chk($sformatf("load_done_c%0d", c), 32'(load_done),
                32'(c == N + 1));
            if (c > N) begin
                chk("tail_weight", 32'(weight_out), 0);
                chk("tail_bnd", 32'(boundary_condition_out), 2);
            end
        end
        @(negedge clk);
        global_stage = '0;
        #1;
        chk("load_done_after", 32'(load_done), 32'(n + 1 == N + 1));
    endtask

    task automatic check_chain(input string tag);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s_w%0d", tag, i), 32'(cw[i]), 32'(vec[i].lw));
            chk($sformatf("%s_b%0d", tag, i), 32'(cb[i]), 32'(vec[i].lb));
        end
    endtask

    initial begin
        vec[0] = '{2, 0, 1, 1};
        vec[1] = '{1, 0, 2, 0};
        vec[2] = '{2, 1, 2, 3};
        vec[3] = '{0, 2, 1, 0};
        vec[4] = '{1, 0, 0, 2};
        vec[5] = '{2, 3, 2, 1};
        vec[6] = '{2, 0, 1, 0};
        vec[7] = '{1, 1, 2, 0};

        repeat (2) @(negedge clk);
        #1;
        chk("rst_s_ready", 32'(s_ready), 0);
        chk("rst_params_ready", 32'(params_ready), 0);
        chk("rst_load_done", 32'(load_done), 0);
        chk("rst_load_error", 32'(load_error), 0);
        chk("rst_weight", 32'(weight_out), 0);
        chk("rst_bnd", 32'(boundary_condition_out), 2);
        @(negedge clk);
        reset = 1;

        // Basic load.
        send_range(0, 7, 7, 0);
        chk("t2_params_ready", 32'(params_ready), 1);
        chk("t2_s_ready", 32'(s_ready), 0);
        chk("t2_head_w", 32'(weight_out), 2);
        chk("t2_head_b", 32'(boundary_condition_out), 0);
        run_load(8);
        check_chain("t2");
        chk("t2_params_after", 32'(params_ready), 0);
        chk("t2_error", 32'(load_error), 0);

        // Gapped input stream.
        send_range(0, 7, 7, 1);
        chk("t3_s_ready_full", 32'(s_ready), 0);
        chk("t3_params_ready", 32'(params_ready), 1);
        run_load(8);
        check_chain("t3");

        // Early s_last.
        send_range(0, 3, 3, 0);
        chk("t4_error", 32'(load_error), 1);
        chk("t4_params_ready", 32'(params_ready), 0);
        chk("t4_s_ready", 32'(s_ready), 1);
        send_range(0, 0, -1, 0);
        chk("t4_error_cleared", 32'(load_error), 0);
        send_range(1, 7, 7, 0);
        chk("t4_params_ready2", 32'(params_ready), 1);
        run_load(8);
        check_chain("t4");

        // Stage drops out of loading early.
        send_range(0, 7, 7, 0);
        run_load(5);
        @(negedge clk);
        #1;
        chk("t5_error", 32'(load_error), 1);
        chk("t5_params_ready", 32'(params_ready), 0);
        chk("t5_s_ready_idle", 32'(s_ready), 1);

        // Over-long loading.
        send_range(0, 7, 7, 0);
        chk("t6_error_cleared", 32'(load_error), 0);
        run_load(10);
        @(negedge clk);
        #1;
        chk("t6_load_done_once", 32'(load_done), 0);
        chk("t6_error_idle_load", 32'(load_error), 1);
        chk("t6_link0_w", 32'(cw[0]), 0);
        chk("t6_link0_b", 32'(cb[0]), 2);
        chk("t6_link1_b", 32'(cb[1]), 2);
        chk("t6_link2_w", 32'(cw[2]), 32'(vec[7].w));

        // Reset during streaming.
        send_range(0, 7, 7, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            global_stage = PL;
        end
        @(negedge clk);
        reset = 0;
        global_stage = '0;
        #1;
        chk("t1_weight", 32'(weight_out), 0);
        chk("t1_bnd", 32'(boundary_condition_out), 2);
        chk("t1_params_ready", 32'(params_ready), 0);
        chk("t1_s_ready", 32'(s_ready), 0);
        chk("t1_error", 32'(load_error), 0);
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        #1;
        chk("t1_idle_ready", 32'(s_ready), 1);
        send_range(0, 7, 7, 0);
        chk("t1_params_ready2", 32'(params_ready), 1);
        run_load(8);
        check_chain("t1");
        chk("t1_error_end", 32'(load_error), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
